// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and timing defaults for the pong ball datapath
// Purpose: 3-bit state codes for ball_draw_control plus default serve delay
//          and render watchdog limit.
// Ports:   none (package).
package pong_pkg;

  localparam int unsigned SERVE_FRAMES_DEF = 30;
  localparam int unsigned WATCHDOG_DEF     = 524288;

  localparam logic [2:0] ST_INIT_BLACK  = 3'd0;
  localparam logic [2:0] ST_WAIT_FRAME  = 3'd1;
  localparam logic [2:0] ST_CLEAR       = 3'd2;
  localparam logic [2:0] ST_DRAW        = 3'd3;
  localparam logic [2:0] ST_SCORE_BLACK = 3'd4;
  localparam logic [2:0] ST_SERVE_WAIT  = 3'd5;

  typedef enum logic [2:0] {
    S_INIT_BLACK  = ST_INIT_BLACK,
    S_WAIT_FRAME  = ST_WAIT_FRAME,
    S_CLEAR       = ST_CLEAR,
    S_DRAW        = ST_DRAW,
    S_SCORE_BLACK = ST_SCORE_BLACK,
    S_SERVE_WAIT  = ST_SERVE_WAIT
  } state_e;

endpackage

// File: rtl/op_watchdog.sv
// rtl/op_watchdog.sv - cycle watchdog for render operations
// Purpose: counts enabled cycles and flags expiry on the limit-th one.
// Ports:   clk, resetn     - clock, synchronous active-low reset
//          clear_i         - zero the count at the next edge
//          count_en_i      - count this cycle
//          limit_i [W]     - number of cycles allowed
//          expired_o       - high during the limit-th counted cycle
module op_watchdog #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear_i,
  input  logic         count_en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // count_q holds the number of cycles already spent, so the current cycle
  // is the limit-th one when count_q reaches limit-1.
  assign expired_o = count_en_i && (count_q == (limit_i - W'(1)));

  always_ff @(posedge clk) begin
    if (!resetn || clear_i) begin
      count_q <= '0;
    end else if (count_en_i) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/ball_draw_control.sv
// rtl/ball_draw_control.sv - frame sequencer for ball erase/draw, scoring and serve
// Purpose: sequences renderer requests per frame, handles score blackout and
//          serve delay, counts dropped frames and aborts stuck render operations.
// Ports:   clk, resetn                         - clock, synchronous active-low reset
//          enable                              - play enable (low pauses)
//          frameTick                           - one-cycle frame strobe
//          lhs_scored, rhs_scored              - score levels
//          done_clearOld/drawNew/blackScreen   - renderer completion strobes
//          clear_old, draw_new, black_screen   - renderer request levels
//          phys_enable                         - ball physics enable
//          lhs_point, rhs_point                - scoreboard increment pulses
//          fault                               - watchdog abort pulse
//          overrun_cnt [CNT_W]                 - saturating dropped-frame count
module ball_draw_control
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int unsigned WATCHDOG     = WATCHDOG_DEF,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             frameTick,
  input  logic             lhs_scored,
  input  logic             rhs_scored,
  input  logic             done_clearOld,
  input  logic             done_drawNew,
  input  logic             done_blackScreen,
  output logic             clear_old,
  output logic             draw_new,
  output logic             black_screen,
  output logic             phys_enable,
  output logic             lhs_point,
  output logic             rhs_point,
  output logic             fault,
  output logic [CNT_W-1:0] overrun_cnt
);

  localparam int unsigned WD_W = $clog2(WATCHDOG + 1);
  localparam int unsigned SV_W = $clog2(SERVE_FRAMES + 1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [SV_W-1:0]  serve_q, serve_d;
  logic [CNT_W-1:0] overrun_q, overrun_d;
  logic             lhs_pt_q, lhs_pt_d;
  logic             rhs_pt_q, rhs_pt_d;
  logic             watched;
  logic             wd_expired;
  logic             wd_clear;

  assign watched = (state_q == S_CLEAR) || (state_q == S_DRAW) ||
                   (state_q == S_INIT_BLACK) || (state_q == S_SCORE_BLACK);

  // An abort back into S_INIT_BLACK from S_INIT_BLACK is not a state change,
  // so expiry clears the count explicitly.
  assign wd_clear = (state_d != state_q) || wd_expired;

  op_watchdog #(
    .W(WD_W)
  ) u_watchdog (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (wd_clear),
    .count_en_i(watched),
    .limit_i   (WD_W'(WATCHDOG)),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    serve_d   = (state_q == S_SERVE_WAIT) ? serve_q : '0;
    lhs_pt_d  = 1'b0;
    rhs_pt_d  = 1'b0;

    // A tick that arrives while rendering is deferred once; further ones are dropped.
    if ((state_q == S_CLEAR || state_q == S_DRAW) && frameTick) begin
      if (pending_q) begin
        if (overrun_q != '1) overrun_d = overrun_q + CNT_W'(1);
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_INIT_BLACK:  if (done_blackScreen) state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (enable) begin
          if (lhs_scored || rhs_scored) begin
            state_d   = S_SCORE_BLACK;
            pending_d = 1'b0;
            lhs_pt_d  = lhs_scored;
            rhs_pt_d  = !lhs_scored;
          end else if (frameTick || pending_q) begin
            state_d   = S_CLEAR;
            pending_d = 1'b0;
          end
        end
      end
      S_CLEAR:       if (done_clearOld)    state_d = S_DRAW;
      S_DRAW:        if (done_drawNew)     state_d = S_WAIT_FRAME;
      S_SCORE_BLACK: if (done_blackScreen) state_d = S_SERVE_WAIT;
      S_SERVE_WAIT: begin
        if (frameTick) begin
          if (serve_q == SV_W'(SERVE_FRAMES - 1)) state_d = S_WAIT_FRAME;
          else serve_d = serve_q + SV_W'(1);
        end
      end
      default:       state_d = S_INIT_BLACK;
    endcase

    if (wd_expired) begin
      state_d   = S_INIT_BLACK;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_INIT_BLACK;
      pending_q <= 1'b0;
      serve_q   <= '0;
      overrun_q <= '0;
      lhs_pt_q  <= 1'b0;
      rhs_pt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      serve_q   <= serve_d;
      overrun_q <= overrun_d;
      lhs_pt_q  <= lhs_pt_d;
      rhs_pt_q  <= rhs_pt_d;
    end
  end

  // Everything except the counter is forced low while reset is held.
  assign black_screen = resetn && (state_q == S_INIT_BLACK || state_q == S_SCORE_BLACK);
  assign clear_old    = resetn && (state_q == S_CLEAR);
  assign draw_new     = resetn && (state_q == S_DRAW);
  assign phys_enable  = resetn && ((state_q == S_WAIT_FRAME && enable) ||
                                   state_q == S_SCORE_BLACK);
  assign lhs_point    = resetn && lhs_pt_q;
  assign rhs_point    = resetn && rhs_pt_q;
  assign fault        = resetn && wd_expired;
  assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_ball_draw_control.sv
// tb/tb_ball_draw_control.sv - self-checking bench for ball_draw_control
module tb_ball_draw_control;

  localparam int WD = 16;
  localparam int SF = 30;
  localparam int CW = 3;
  localparam int OVR_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn, enable, frameTick, lhs_scored, rhs_scored;
  logic done_clearOld, done_drawNew, done_blackScreen;
  logic clear_old, draw_new, black_screen, phys_enable, lhs_point, rhs_point, fault;
  logic [CW-1:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  ball_draw_control #(.SERVE_FRAMES(SF), .WATCHDOG(WD), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .frameTick(frameTick),
    .lhs_scored(lhs_scored), .rhs_scored(rhs_scored),
    .done_clearOld(done_clearOld), .done_drawNew(done_drawNew),
    .done_blackScreen(done_blackScreen),
    .clear_old(clear_old), .draw_new(draw_new), .black_screen(black_screen),
    .phys_enable(phys_enable), .lhs_point(lhs_point), .rhs_point(rhs_point),
    .fault(fault), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: frame-level behaviour tracked per cycle
  typedef enum int {M_BOOT, M_IDLE, M_ERASE, M_PAINT, M_GOAL, M_SERVE} mstate_t;
  mstate_t mst;
  bit mpend, mlp, mrp;
  int movr, mserve, mtime;   // mtime: cycles spent in the current state, including this one

  // Samples of the last checked cycle
  logic s_blk, s_clr, s_drw, s_phys, s_lp, s_rp, s_flt;
  int   s_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit guarded(input mstate_t s);
    return s == M_BOOT || s == M_ERASE || s == M_PAINT || s == M_GOAL;
  endfunction

  function automatic logic [6:0] model_outs();
    bit blk, clr, drw, phys, flt;
    blk  = resetn && (mst == M_BOOT || mst == M_GOAL);
    clr  = resetn && (mst == M_ERASE);
    drw  = resetn && (mst == M_PAINT);
    phys = resetn && ((mst == M_IDLE && enable) || mst == M_GOAL);
    flt  = resetn && guarded(mst) && (mtime == WD);
    return {blk, clr, drw, phys, resetn && mlp, resetn && mrp, flt};
  endfunction

  task automatic model_step();
    mstate_t nxt;
    bit abort;
    if (!resetn) begin
      mst = M_BOOT; mpend = 0; movr = 0; mserve = 0; mtime = 1; mlp = 0; mrp = 0;
      return;
    end
    abort = guarded(mst) && (mtime == WD);
    nxt = mst; mlp = 0; mrp = 0;
    if ((mst == M_ERASE || mst == M_PAINT) && frameTick) begin
      if (mpend) movr = (movr < OVR_MAX) ? movr + 1 : OVR_MAX;
      else mpend = 1;
    end
    case (mst)
      M_BOOT:  if (done_blackScreen) nxt = M_IDLE;
      M_IDLE:  if (enable) begin
                 if (lhs_scored || rhs_scored) begin
                   nxt = M_GOAL; mpend = 0; mlp = lhs_scored; mrp = !lhs_scored;
                 end else if (frameTick || mpend) begin
                   nxt = M_ERASE; mpend = 0;
                 end
               end
      M_ERASE: if (done_clearOld) nxt = M_PAINT;
      M_PAINT: if (done_drawNew) nxt = M_IDLE;
      M_GOAL:  if (done_blackScreen) begin nxt = M_SERVE; mserve = 0; end
      M_SERVE: if (frameTick) begin
                 mserve++;
                 if (mserve == SF) nxt = M_IDLE;
               end
      default: nxt = M_BOOT;
    endcase
    if (abort) begin nxt = M_BOOT; mpend = 0; end
    mtime = (nxt != mst || abort) ? 1 : mtime + 1;
    mst = nxt;
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge, clear strobes.
  task automatic cyc();
    logic [6:0] got;
    @(negedge clk);
    got = {black_screen, clear_old, draw_new, phys_enable, lhs_point, rhs_point, fault};
    check_eq("outs", {25'd0, got}, {25'd0, model_outs()});
    check_eq("overrun", {29'd0, overrun_cnt}, movr);
    {s_blk, s_clr, s_drw, s_phys, s_lp, s_rp, s_flt} = got;
    s_ovr = int'(overrun_cnt);
    @(posedge clk);
    model_step();
    #1;
    frameTick = 0; lhs_scored = 0; rhs_scored = 0;
    done_clearOld = 0; done_drawNew = 0; done_blackScreen = 0;
  endtask

  initial begin
    int n1, n2, n3, at;
    resetn = 0; enable = 1; frameTick = 0; lhs_scored = 0; rhs_scored = 0;
    done_clearOld = 0; done_drawNew = 0; done_blackScreen = 0;
    repeat (2) @(posedge clk);
    #1;
    mst = M_BOOT; mpend = 0; movr = 0; mserve = 0; mtime = 1; mlp = 0; mrp = 0;
    cyc();
    check_eq("rst_black", s_blk, 0);
    cyc();

    // Boot blackout completes on cycle 10
    resetn = 1; n1 = 0;
    for (int c = 1; c <= 10; c++) begin
      done_blackScreen = (c == 10);
      cyc();
      n1 += s_blk;
    end
    cyc();
    check_eq("boot_black_cycles", n1, 10);
    check_eq("boot_black_off", s_blk, 0);
    check_eq("boot_phys", s_phys, 1);

    // Normal frame: 5-cycle clear, 5-cycle draw
    frameTick = 1; cyc();
    n1 = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      done_clearOld = (i == 4); done_drawNew = (i == 9);
      cyc();
      n1 += s_clr; n2 += s_drw;
    end
    cyc();
    check_eq("frame_clear_cycles", n1, 5);
    check_eq("frame_draw_cycles", n2, 5);
    check_eq("frame_back_wait", {s_clr, s_drw, s_phys}, 3'b001);
    check_eq("frame_overrun", s_ovr, 0);

    // Three ticks during one draw
    frameTick = 1; cyc();
    done_clearOld = 1; cyc();
    for (int i = 0; i < 4; i++) begin
      frameTick = (i < 3); done_drawNew = (i == 3);
      cyc();
    end
    cyc();
    check_eq("ovr_after_3_ticks", s_ovr, 2);
    done_clearOld = 1; cyc();
    check_eq("pending_clear", s_clr, 1);
    done_drawNew = 1; cyc();

    // Simultaneous scores with a tick: lhs wins, then 30-tick serve
    lhs_scored = 1; rhs_scored = 1; frameTick = 1; cyc();
    cyc();
    check_eq("score_lhs_pt", s_lp, 1);
    check_eq("score_rhs_pt", s_rp, 0);
    check_eq("score_no_clear_black", {s_clr, s_blk}, 2'b01);
    done_blackScreen = 1; cyc();
    check_eq("score_single_pulse", s_lp, 0);
    for (int t = 1; t <= SF; t++) begin
      frameTick = 1; cyc();
      cyc();
      if (t == SF - 1) check_eq("serve_29_still", s_phys, 0);
    end
    check_eq("serve_30_resume", s_phys, 1);

    // Stuck clear trips the watchdog on its 16th cycle
    frameTick = 1; cyc();
    at = 0;
    for (int c = 1; c <= WD; c++) begin
      cyc();
      if (s_flt && at == 0) at = c;
    end
    check_eq("wd_fault_cycle", at, WD);
    done_blackScreen = 1; cyc();
    check_eq("wd_black_next", {s_blk, s_flt}, 2'b10);

    // Paused: ticks ignored, not latched
    enable = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 8; i++) begin
      frameTick = (i % 2 == 0);
      cyc();
      n1 += s_phys; n2 += s_clr;
    end
    enable = 1; cyc(); cyc();
    n2 += s_clr;
    check_eq("pause_phys", n1, 0);
    check_eq("pause_no_clear", n2, 0);
    check_eq("pause_overrun", s_ovr, 2);

    // Overrun saturation
    frameTick = 1; cyc();
    for (int i = 0; i < 12; i++) begin frameTick = 1; cyc(); end
    done_clearOld = 1; cyc();
    check_eq("ovr_saturate", s_ovr, OVR_MAX);

    // Reset in the middle of a draw
    resetn = 0; cyc();
    check_eq("rst_mid_outs", {s_blk, s_clr, s_drw, s_phys, s_lp, s_rp, s_flt}, 7'd0);
    cyc();
    resetn = 1; cyc();
    check_eq("rst_release_black", s_blk, 1);
    check_eq("rst_release_ovr", s_ovr, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      resetn           = ($urandom_range(0, 199) != 0);
      enable           = ($urandom_range(0, 9) != 0);
      frameTick        = ($urandom_range(0, 4) == 0);
      lhs_scored       = ($urandom_range(0, 29) == 0);
      rhs_scored       = ($urandom_range(0, 29) == 0);
      done_clearOld    = ($urandom_range(0, 5) == 0);
      done_drawNew     = ($urandom_range(0, 5) == 0);
      done_blackScreen = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
